// File: rtl/inverse_key_expand_if.sv
// Streaming handshake bundle for the AES-128 inverse key schedule.
// master: decrypt datapath (start/load, consume); slave: inverse_key_expand.
interface inverse_key_expand_if;
    logic         start;
    logic [127:0] lastKey;
    logic         outReady;
    logic         outValid;
    logic [127:0] roundKey;
    logic [3:0]   roundIndex;
    logic         busy;
    logic         done;

    modport master (
        output start, lastKey, outReady,
        input  outValid, roundKey, roundIndex, busy, done
    );

    modport slave (
        input  start, lastKey, outReady,
        output outValid, roundKey, roundIndex, busy, done
    );
endinterface

// File: rtl/inverse_key_expand.sv
// Iterative AES-128 inverse key schedule: streams round keys NUM_ROUNDS..0.
// Optional INV_KEY_STORE_EN adds parallel allKeys/allValid storage.
module inverse_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                 clock,
    input  logic                 reset_n,
    inverse_key_expand_if.slave  kx
`ifdef INV_KEY_STORE_EN
    ,
    output logic [127:0]         allKeys [NUM_ROUNDS+1],
    output logic                 allValid
`endif
);

    generate
        if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_rounds
            $error("NUM_ROUNDS must be in 1..10");
        end
    endgenerate

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bits [2047-8b -: 8], i.e. {~b,3'b111}.
    function automatic logic [7:0] f_sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] f_rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t       r_state;
    logic [127:0] r_key;
    logic [3:0]   r_idx;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [31:0]  w_rot, w_sub;
    logic [127:0] w_prev;
    logic         w_load;
    logic         w_accept;

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    // Undo the forward recurrence: later words are XORs of earlier ones.
    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;

    assign w_rot = {w_p3[23:0], w_p3[31:24]};
    assign w_sub = {f_sbox(w_rot[31:24]), f_sbox(w_rot[23:16]),
                    f_sbox(w_rot[15:8]),  f_sbox(w_rot[7:0])};
    assign w_p0  = w_w0 ^ w_sub ^ {f_rcon(r_idx), 24'h0};

    assign w_prev   = {w_p0, w_p1, w_p2, w_p3};
    assign w_load   = (r_state == S_IDLE) && kx.start;
    assign w_accept = r_valid && kx.outReady;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (kx.start) begin
                        r_key   <= kx.lastKey;
                        r_idx   <= 4'(NUM_ROUNDS);
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_accept) begin
                        if (r_idx != 4'd0) begin
                            r_key <= w_prev;
                            r_idx <= r_idx - 4'd1;
                        end else begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign kx.outValid   = r_valid;
    assign kx.roundKey   = r_key;
    assign kx.roundIndex = r_idx;
    assign kx.busy       = r_busy;
    assign kx.done       = r_done;

`ifdef INV_KEY_STORE_EN
    logic [127:0] r_all [NUM_ROUNDS+1];
    logic         r_all_valid;

    // Entry layout matches a forward ExpandKey: index = round number.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_all[i] <= '0;
            end
            r_all_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_all_valid <= 1'b0;
            end
            if (w_accept) begin
                r_all[r_idx] <= r_key;
                if (r_idx == 4'd0) begin
                    r_all_valid <= 1'b1;
                end
            end
        end
    end

    assign allKeys  = r_all;
    assign allValid = r_all_valid;
`endif

endmodule

// File: tb/tb_inverse_key_expand.sv
// Directed bench for inverse_key_expand (FIPS-197 A.1 and zero-key schedules).
// Build with +define+INV_KEY_STORE_EN to also cover the key store.
module tb_inverse_key_expand;

    localparam logic [127:0] A1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_LAST  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inverse_key_expand_if kx();

`ifdef INV_KEY_STORE_EN
    logic [127:0] allKeys [11];
    logic         allValid;
`endif

    inverse_key_expand #(.NUM_ROUNDS(10)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .kx      (kx)
`ifdef INV_KEY_STORE_EN
        ,
        .allKeys (allKeys),
        .allValid(allValid)
`endif
    );

    typedef struct {
        logic [127:0] last;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs[$];
    logic [127:0] a1 [11];
    logic [127:0] got [11];
    int           nchk = 0;
    int           nfail = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Starts in the current cycle, ends at the cycle done is high.
    task automatic run_seq(input logic [127:0] key, input bit rnd,
                           input int poke);
        int           cyc;
        int           ndone;
        int           exp_idx;
        bit           fin;
        logic         pv, pr;
        logic [127:0] pk;
        logic [3:0]   pi;
        for (int g = 0; g < 11; g++) got[g] = '0;
        kx.lastKey  = key;
        kx.start    = 1'b1;
        kx.outReady = 1'b1;
        @(posedge clk);
        #1;
        kx.start = 1'b0;
        check("first_valid", kx.outValid, 1);
        check("first_busy", kx.busy, 1);
        check("first_idx", kx.roundIndex, 10);
        exp_idx = 10;
        cyc = 0;
        ndone = 0;
        fin = 0;
        while (!fin && cyc < 300) begin
            kx.outReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke >= 0 && kx.outValid && kx.roundIndex == 4'(poke)) begin
                kx.start   = 1'b1;
                kx.lastKey = Z_LAST;
            end
            pv = kx.outValid;
            pr = kx.outReady;
            pk = kx.roundKey;
            pi = kx.roundIndex;
            @(posedge clk);
            #1;
            cyc++;
            kx.start = 1'b0;
            if (kx.done) ndone++;
            if (pv && !pr) begin
                check("stall_key", kx.roundKey, pk);
                check("stall_idx", kx.roundIndex, pi);
            end
            if (pv && pr) begin
                check("idx_order", pi, exp_idx);
                got[pi] = pk;
                if (pi == 4'd0) fin = 1;
                else exp_idx--;
            end
        end
        check("seq_complete", fin, 1);
        check("done_pulse", kx.done, 1);
        check("done_count", ndone, 1);
        check("end_valid", kx.outValid, 0);
        check("end_busy", kx.busy, 0);
        if (!rnd) check("seq_cycles", cyc, 11);
    endtask

    initial begin
        logic [127:0] cur;
        bit           have;
        int           w;

        a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1[10] = A1_LAST;
        for (int i = 10; i >= 0; i--) vecs.push_back('{A1_LAST, i, a1[i]});
        vecs.push_back('{Z_LAST, 10, Z_LAST});
        vecs.push_back('{Z_LAST, 1, Z_R1});
        vecs.push_back('{Z_LAST, 0, 128'h0});

        kx.start    = 1'b0;
        kx.lastKey  = '0;
        kx.outReady = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", kx.outValid, 0);
        check("rst_key", kx.roundKey, 0);
        check("rst_idx", kx.roundIndex, 0);
        check("rst_busy", kx.busy, 0);
        check("rst_done", kx.done, 0);
        rst_n = 1'b1;
        idle_cycle();

        have = 0;
        cur  = '0;
        foreach (vecs[i]) begin
            if (!have || vecs[i].last != cur) begin
                run_seq(vecs[i].last, 0, -1);
                idle_cycle();
                check("done_single", kx.done, 0);
                cur  = vecs[i].last;
                have = 1;
            end
            check($sformatf("vec%0d_idx%0d", i, vecs[i].idx),
                  got[vecs[i].idx], vecs[i].exp);
        end

        run_seq(A1_LAST, 1, -1);
        idle_cycle();
        check("rnd_done_single", kx.done, 0);
        for (int i = 0; i <= 10; i++)
            check($sformatf("rnd_idx%0d", i), got[i], a1[i]);

        run_seq(A1_LAST, 0, 5);
        for (int i = 0; i <= 10; i++)
            check($sformatf("poke_idx%0d", i), got[i], a1[i]);
        run_seq(Z_LAST, 0, -1);
        check("b2b_idx1", got[1], Z_R1);
        check("b2b_idx0", got[0], 128'h0);
        idle_cycle();

        kx.lastKey  = A1_LAST;
        kx.start    = 1'b1;
        kx.outReady = 1'b1;
        idle_cycle();
        kx.start = 1'b0;
        w = 0;
        while (kx.roundIndex != 4'd4 && w < 20) begin
            idle_cycle();
            w++;
        end
        check("reach_idx4", kx.roundIndex, 4);
        rst_n = 1'b0;
        idle_cycle();
        check("abort_valid", kx.outValid, 0);
        check("abort_busy", kx.busy, 0);
        check("abort_key", kx.roundKey, 0);
        check("abort_done", kx.done, 0);
        rst_n = 1'b1;
        idle_cycle();
        check("abort_no_done", kx.done, 0);
        run_seq(A1_LAST, 0, -1);
        check("fresh_idx0", got[0], a1[0]);
        check("fresh_idx9", got[9], a1[9]);
        idle_cycle();

`ifdef INV_KEY_STORE_EN
        run_seq(A1_LAST, 0, -1);
        check("store_valid_done", allValid, 1);
        for (int i = 0; i <= 10; i++)
            check($sformatf("store_key%0d", i), allKeys[i], a1[i]);
        idle_cycle();
        check("store_valid_hold", allValid, 1);
        kx.lastKey = Z_LAST;
        kx.start   = 1'b1;
        idle_cycle();
        kx.start = 1'b0;
        check("store_valid_clear", allValid, 0);
        w = 0;
        while (!kx.done && w < 40) begin
            idle_cycle();
            w++;
        end
        check("store_drain_done", kx.done, 1);
        check("store_zero_key0", allKeys[0], 128'h0);
        idle_cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/inverse_key_expand.md
Name: inverse_key_expand

Overview:
- Iterative AES-128 inverse key schedule for the decrypt datapath.
- Takes the final round key (round NUM_ROUNDS) and walks the schedule backwards, one round key per accepted handshake, ending at round 0 (the cipher key).
- Inverse counterpart of ExpandKey: decryption consumes round keys last-to-first without first running a full forward expansion.

Parameters:
- NUM_ROUNDS, 10, index of the loaded key and count of backward steps; legal range 1..10; elaboration error outside that range.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- start  input  1  load lastKey and begin a sequence; honoured only when busy=0
- lastKey  input  128  round-NUM_ROUNDS key; word0 = bits[127:96], byte0 = bits[127:120] (FIPS-197 order)
- outReady  input  1  consumer accepts roundKey this cycle
- outValid  output  1  roundKey/roundIndex valid
- roundKey  output  128  current round key, same word/byte order as lastKey
- roundIndex  output  4  round number of roundKey, NUM_ROUNDS down to 0
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse after the round-0 key is accepted

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE; outValid=0, roundKey=0, roundIndex=0, busy=0, done=0.
- Reset dominates every other input. A reset mid-sequence aborts it; no done pulse.
- IDLE:
  - start=1 at edge t: register lastKey, roundIndex=NUM_ROUNDS, go to EMIT.
  - At t+1: outValid=1, busy=1.
- EMIT, handshake outValid && outReady at an edge:
  - roundIndex>0: roundKey becomes the previous round key and roundIndex decrements. outValid stays 1. With outReady held high, one key per cycle.
  - roundIndex==0: go to IDLE; outValid=0, busy=0, done=1 for exactly one cycle. roundKey/roundIndex hold their last values.
- Backpressure: while outValid && !outReady, roundKey and roundIndex hold stable.
- start while busy=1 is ignored. start in the same cycle done is asserted is accepted, since state is IDLE then.
- Backward step from round r key w0..w3 (32-bit words) to round r-1 key p0..p3:
  - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36
- SubWord uses four forward S-box lookups. The step is purely combinational from the key register; no extra latency.
- Latency: first key 1 cycle after start; full sequence NUM_ROUNDS+1 cycles with outReady=1; done on cycle NUM_ROUNDS+2 after start.

Optional Feature:
INV_KEY_STORE_EN
- Defined:
  - Adds output allKeys (roundKeys_t, NUM_ROUNDS+1 entries) and output allValid (1 bit).
  - Each accepted key is written to entry roundIndex.
  - allValid asserts together with done and stays high until the next accepted start or reset. Both clear it; entries reset to 0.
  - Lets the decrypt pipeline read every key in parallel, in the same layout ExpandKey produces.
- Undefined: no storage, no extra ports; streaming interface only.

Test Plan:
- FIPS-197 A.1, lastKey=d014f9a8c9ee2589e13f0cc8b6630ca6, outReady=1:
  - 11 keys on consecutive cycles
  - idx9 = ac7766f319fadc2128d12941575c006e
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx0 = 2b7e151628aed2a6abf7158809cf4f3c
  - done one cycle after idx0
- Zero cipher key, lastKey=b4ef5bcb3e92e21123e951cf6f8f188e:
  - idx1 = 62636363626363636263636362636363
  - idx0 = all zeros
- Random outReady (~50%) on the A.1 vector:
  - key/index stable during stalls
  - same 11-key sequence
  - exactly one done
- start pulsed at idx 5 of a running sequence -> ignored, sequence completes unchanged. Back-to-back start on the done cycle -> new sequence begins next cycle.
- reset_n low at idx 4 -> next cycle: outValid=0, busy=0, roundKey=0, no done. A fresh start runs correctly.
- INV_KEY_STORE_EN, A.1 vector:
  - allValid with done
  - allKeys equals ExpandKey(2b7e151628aed2a6abf7158809cf4f3c) output for all 11 entries
  - next start clears allValid
